// File: rtl/mul_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_seq
// Description : Iterative multiply/divide sequencer in front of the multiplier
//               register (MR) and the accumulator. One shift/add (signed
//               multiply) or shift/subtract-restore (unsigned divide) step is
//               taken per clock, for WIDTH steps.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      launch request, accepted only while idle
//   op_sel  in   1      0 = signed multiply, 1 = unsigned divide
//   opa     in   WIDTH  multiplicand / dividend, sampled at accept
//   opb     in   WIDTH  multiplier / divisor, sampled at accept
//   busy    out  1      high while running and during the done cycle
//   done    out  1      one-cycle completion pulse
//   res_hi  out  WIDTH  mul: product high half; div: remainder
//   res_lo  out  WIDTH  mul: product low half;  div: quotient (to MR_IN)
//   ovf     out  1      mul: product does not fit WIDTH signed bits
//   dz      out  1      div: divisor was zero
//
// Revision    : 1.0  initial release
// ============================================================================
module mul_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             ovf,
    output logic             dz
);

    localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Working registers. r_m is the multiplicand magnitude or the divisor;
    // r_q holds the multiplier magnitude (shifted out LSB first) or the
    // dividend (shifted out MSB first while quotient bits shift in).
    logic               r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic               r_ovf;
    logic               r_dz;

    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_unused;

    assign w_last = (r_cnt == c_last);

    // Magnitudes for the multiply; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
    // still fits as an unsigned WIDTH-bit value.
    assign w_abs_a = opa[WIDTH-1] ? -opa : opa;
    assign w_abs_b = opb[WIDTH-1] ? -opb : opb;

    // Multiply step: conditional add into the upper half (carry kept in
    // w_sum[WIDTH]), then shift {carry, acc, q} right by one.
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Divide step: the WIDTH+1 bit partial remainder is the previous
    // remainder shifted left with the next dividend bit. The subtract is one
    // bit wider again so its sign bit is the restore decision.
    assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_m};
    assign w_ge     = ~w_diff[WIDTH+1];

    // A successful subtract always leaves a value below the divisor, so
    // w_diff[WIDTH] is zero whenever it would be selected.
    assign w_unused = w_diff[WIDTH];

    always_comb begin
        w_acc_nxt = w_sum[WIDTH:1];
        w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        if (r_op) begin
            w_acc_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
        end
    end

    // Final product with the sign restored; used only on the last step.
    assign w_mag  = {w_acc_nxt, w_q_nxt};
    assign w_prod = r_neg ? -w_mag : w_mag;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= 1'b0;
            r_neg    <= 1'b0;
            r_m      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op_sel;
                        r_neg <= ~op_sel & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_m   <= op_sel ? opb : w_abs_b;
                        r_q   <= op_sel ? opa : w_abs_a;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + c_one;
                    if (w_last) begin
                        if (r_op) begin
                            // With a zero divisor every subtract succeeds, so
                            // the quotient is all ones and the dividend
                            // shifts through unchanged into the remainder.
                            r_res_hi <= w_acc_nxt;
                            r_res_lo <= w_q_nxt;
                            r_ovf    <= 1'b0;
                            r_dz     <= (r_m == '0);
                        end else begin
                            r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_res_lo <= w_prod[WIDTH-1:0];
                            r_ovf    <= (w_prod[2*WIDTH-1:WIDTH] !=
                                         {WIDTH{w_prod[WIDTH-1]}});
                            r_dz     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_hi = r_res_hi;
    assign res_lo = r_res_lo;
    assign ovf    = r_ovf;
    assign dz     = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_seq
// Description : Directed self-checking bench for mul_div_seq with
//               hand-computed expected results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_div_seq;

    localparam int W = 16;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         op_sel = 1'b0;
    logic [W-1:0] opa    = '0;
    logic [W-1:0] opb    = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;
    logic         ovf;
    logic         dz;

    int n_vec = 0;
    int n_err = 0;

    mul_div_seq #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sel (op_sel),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .ovf    (ovf),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: plain op; 1: extra start pulses at cycles 3 and 16 after
    // accept; 2: start held high, expect relaunch 18 edges after accept.
    task automatic run_op(input string tag, input logic op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic eovf, input logic edz, input int mode);
        logic [W-1:0] ph, pl;
        int           done_cnt, done_at;
        logic         hold_bad, b17, b18, drained;
        ph = res_hi; pl = res_lo;
        done_cnt = 0; done_at = -1; hold_bad = 1'b0; b17 = 1'b0; b18 = 1'b0;
        op_sel = op; opa = a; opb = b; start = 1'b1;
        tick;                                   // accept edge
        if (mode != 2) start = 1'b0;
        opa = ~a; opb = W'($urandom); op_sel = ~op;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= W + 2; k++) begin
            tick;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    check({tag, "_hi"},  32'(res_hi), 32'(eh));
                    check({tag, "_lo"},  32'(res_lo), 32'(el));
                    check({tag, "_ovf"}, 32'(ovf),    32'(eovf));
                    check({tag, "_dz"},  32'(dz),     32'(edz));
                end
            end
            if (k < W && (res_hi !== ph || res_lo !== pl)) hold_bad = 1'b1;
            if (k == W + 1) b17 = busy;
            if (k == W + 2) b18 = busy;
            if (mode == 1) start = (k == 3 || k == W);
        end
        check({tag, "_done_at"},  32'(done_at),  32'(W));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_run_hold"}, 32'(hold_bad), 32'd0);
        check({tag, "_relaunch"}, {30'd0, b17, b18},
              (mode == 2) ? 32'd1 : 32'd0);
        if (mode == 2) begin
            start = 1'b0;
            drained = 1'b0;
            for (int k = 0; k < W + 4 && !drained; k++) begin
                tick;
                if (done) drained = 1'b1;
            end
            check({tag, "_drain"}, 32'(drained), 32'd1);
            tick;
        end else begin
            check({tag, "_keep"}, {res_hi, res_lo}, {eh, el});
        end
    endtask

    initial begin
        logic seen;

        // Reset state
        repeat (3) tick;
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_done", 32'(done),   32'd0);
        check("rst_hi",   32'(res_hi), 32'd0);
        check("rst_lo",   32'(res_lo), 32'd0);
        check("rst_ovf",  32'(ovf),    32'd0);
        check("rst_dz",   32'(dz),     32'd0);
        rst_n = 1'b1;
        tick;

        // Signed multiply
        run_op("mul_3xm5",    1'b0, 16'h0003, 16'hFFFB, 16'hFFFF, 16'hFFF1, 1'b0, 1'b0, 0);
        run_op("mul_minsq",   1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b1, 1'b0, 0);
        run_op("mul_max1",    1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 0);
        run_op("mul_m1m1",    1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 1'b0, 0);
        run_op("mul_min_m1",  1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b1, 1'b0, 0);
        run_op("mul_min_1",   1'b0, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 0);
        run_op("mul_m256",    1'b0, 16'hFF00, 16'h0100, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);

        // Unsigned divide
        run_op("div_100_7",   1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 1'b0, 0);
        run_op("div_dz",      1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 0);
        run_op("div_ffff_1",  1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0);
        run_op("div_5_9",     1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 1'b0, 0);
        run_op("div_big",     1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);

        // Handshake: ignored pulses, then start held high
        run_op("hs_pulse",    1'b0, 16'h0003, 16'hFFFB, 16'hFFFF, 16'hFFF1, 1'b0, 1'b0, 1);
        run_op("hs_hold",     1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 1'b0, 2);

        // Hold: results stay put while operands wiggle
        run_op("div_pre_hold", 1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            opa = W'($urandom); opb = W'($urandom); op_sel = ~op_sel;
            tick;
            check("hold_res",   {res_hi, res_lo}, 32'h0002_000E);
            check("hold_flags", {30'd0, ovf, dz}, 32'd0);
        end

        // Reset mid-operation (prior result nonzero with ovf set)
        run_op("mul_pre_rst", 1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b1, 1'b0, 0);
        op_sel = 1'b0; opa = 16'h0003; opb = 16'h0005; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        rst_n = 1'b0;
        tick;
        check("mrst_busy", 32'(busy),   32'd0);
        check("mrst_done", 32'(done),   32'd0);
        check("mrst_hi",   32'(res_hi), 32'd0);
        check("mrst_lo",   32'(res_lo), 32'd0);
        check("mrst_ovf",  32'(ovf),    32'd0);
        check("mrst_dz",   32'(dz),     32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (done) seen = 1'b1;
        end
        check("mrst_nodone", 32'(seen), 32'd0);

        // Recovery after reset
        run_op("div_post_rst", 1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
